cla_seq_ctrl: RTL and testbench
===============================

# cla_seq_ctrl

Nibble-serial adder controller that shares one 4-bit `cla` instance between two requesters. It arbitrates round-robin between two W-bit add requests and feeds the granted operands through the `cla` one nibble per cycle, least significant nibble first. It chains the carry between nibbles and returns the W-bit sum plus carry-out on a valid/ready response port. It is the sequencing layer that lets the arithmetic path support widths beyond 4 bits without replicating the adder.

## Interface
- `W`, 16, operand width; must be a multiple of 4 and at least 4.
- `clk` input 1, single clock; all state updates on its rising edge.
- `rst` input 1, synchronous, active-high reset.
- `req0_valid` input 1, requester 0 has an operation pending.
- `req0_ready` output 1, requester 0's operation is accepted this cycle.
- `req0_a`, `req0_b` input W, requester 0 operands.
- `req0_cin` input 1, requester 0 carry-in.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same as the requester 0 ports, for requester 1.
- `rsp_valid` output 1, a result is available.
- `rsp_ready` input 1, the consumer takes the result.
- `rsp_id` output 1, index of the requester that owns the result.
- `rsp_sum` output W, the sum.
- `rsp_cout` output 1, carry out of bit W-1.

## Operation
- `NIB` = W/4. States are IDLE, ADD and RESP.
- **IDLE**
  - Grant when at least one valid is high.
  - If only one valid is high, grant that requester.
  - If both are high, grant the requester not in `last_grant`.
  - `reqN_ready` = (state==IDLE) & grantN. It is combinational and at most one is high.
  - On accept: latch a, b, cin and id. Set `last_grant` = id, nibble index k = 0, then go to ADD.
- **ADD** (one cycle per nibble)
  - Drive `cla` with ain = a[4k+3:4k], bin = b[4k+3:4k], cin = carry register (the latched cin when k=0).
  - Write s into sum[4k+3:4k].
  - `cla` exposes only s, so the controller derives nibble carry-out as c4 = (a3 & b3) | ((a3 ^ b3) & ~s3).
  - Register c4 as the carry, then increment k.
  - After the nibble with k = NIB-1, set cout = c4 and go to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - `rsp_id`, `rsp_sum` and `rsp_cout` stay stable while `rsp_ready` = 0.
  - On `rsp_valid & rsp_ready`, go to IDLE.
- Arithmetic is modulo 2^W. The carry out of the top bit appears only on `rsp_cout`.
- Reset values: state=IDLE, `last_grant`=1 (so requester 0 wins the first tie), `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_cout`=0, both `reqN_ready`=0 while `rst` is high.
- Reset in ADD or RESP aborts the operation. No response is produced and the result is discarded.

## Timing
- Accept edge is E, when valid & ready are both high.
- ADD occupies the NIB cycles following E. `rsp_valid` rises NIB edges after E; for W=16 that is E+4.
- If `rsp_ready` is already high, the response completes in its first cycle. The next accept is then possible at E+NIB+2.
- Peak throughput is one operation per NIB+2 cycles.
- No ready is asserted outside IDLE. Requesters must hold valid and operands until ready.
- Valid dropping before grant is legal and causes no accept.
- A request arriving in the same cycle the controller returns to IDLE is evaluated in the next cycle.

## Structure
- Package `cla_seq_pkg`: state encoding constants (IDLE, ADD, RESP) and the nibble width constant 4.
- One sub-module: the existing `cla` (ports ain[3:0], bin[3:0], cin, s[3:0]), instantiated once and shared.
- The arbiter, nibble counter, carry register and result register live in `cla_seq_ctrl`.

## Test plan
- req0 a=0x0004, b=0x0007, cin=1 → rsp_sum=0x000C, rsp_cout=0, rsp_id=0, `rsp_valid` at E+4.
- req1 a=0xFFFF, b=0x0000, cin=1 → rsp_sum=0x0000, rsp_cout=1. This exercises the carry ripple through all nibbles.
- req0 a=0x8000, b=0x8000, cin=0 → rsp_sum=0x0000, rsp_cout=1. This checks the derived-carry case where a3 & b3 is set.
- Both valid from reset with held operands (req0: 0x0005+0x0002, req1: 0x0008+0x0005+1) → grants in order 0, 1, 0, 1. Sums are 0x0007 and 0x000E.
- Hold `rsp_ready`=0 for 3 cycles in RESP → `rsp_*` remain stable, both readies stay 0, and exactly one transfer occurs.
- Assert `rst` during the 2nd ADD cycle → no `rsp_valid`, all outputs return to reset values. The next request 0x1234+0x4321 gives 0x5555.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared encodings for the nibble-serial adder controller.
package cla_seq_pkg;

  // Width of the shared adder slice; operands are walked through it one nibble at a time.
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cla.sv
// 4-bit carry-lookahead adder slice. Only the sum is exposed; the carry out
// of bit 3 is reconstructed by the controller.
module cla (
  input  logic [3:0] ain,
  input  logic [3:0] bin,
  input  logic       cin,
  output logic [3:0] s
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = ain & bin;
  assign p = ain ^ bin;

  // Lookahead carries into each bit position.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

endmodule

// File: rtl/cla_seq_ctrl.sv
// Nibble-serial adder controller: round-robin arbitration between two
// requesters, LS-nibble-first addition through one shared 4-bit cla, and a
// valid/ready response port that holds the result until it is taken.
module cla_seq_ctrl
  import cla_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout
);

  localparam int NIB = W / NIB_W;
  localparam int K_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NIB - 1);
  localparam logic [K_W-1:0] K_ONE  = K_W'(1);

  state_t         state;
  logic           last_grant;
  logic [K_W-1:0] k;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           carry_q;

  logic           grant0;
  logic           grant1;
  logic [K_W+1:0] base;
  logic [3:0]     nib_a;
  logic [3:0]     nib_b;
  logic [3:0]     nib_s;
  logic           c4;

  // Round-robin choice: a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = ~last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Ready is only offered in IDLE and never while reset is held.
  assign req0_ready = (state == IDLE) & grant0 & ~rst;
  assign req1_ready = (state == IDLE) & grant1 & ~rst;

  assign base  = {k, 2'b00};
  assign nib_a = a_q[base +: NIB_W];
  assign nib_b = b_q[base +: NIB_W];

  cla u_cla (
    .ain (nib_a),
    .bin (nib_b),
    .cin (carry_q),
    .s   (nib_s)
  );

  // The slice hides its carry; a top-bit carry happened iff both bits were set,
  // or exactly one was set and the sum bit came out 0.
  assign c4 = (nib_a[3] & nib_b[3]) | ((nib_a[3] ^ nib_b[3]) & ~nib_s[3]);

  // Sequencer: accept in IDLE, one nibble per cycle in ADD, hold the result in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      k          <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            a_q        <= grant1 ? req1_a : req0_a;
            b_q        <= grant1 ? req1_b : req0_b;
            carry_q    <= grant1 ? req1_cin : req0_cin;
            rsp_id     <= grant1;
            last_grant <= grant1;
            k          <= '0;
            state      <= ADD;
          end
        end
        ADD: begin
          rsp_sum[base +: NIB_W] <= nib_s;
          carry_q                <= c4;
          k                      <= k + K_ONE;
          if (k == K_LAST) begin
            rsp_cout  <= c4;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed bench for the nibble-serial adder controller (W=16).
module tb_cla_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_cin, req1_cin;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [15:0] rsp_sum;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  cla_seq_ctrl #(.W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for rsp_valid after the accept edge and checks the latency.
  task automatic wait_rsp(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 10) begin
      cyc();
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
  endtask

  // Presents one request alone, checks ready, and completes the accept edge.
  task automatic issue(input string tag, input bit sel, input logic [15:0] a,
                       input logic [15:0] b, input bit cin);
    if (sel) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    #1;
    chk({tag, "_ready_own"}, sel ? req1_ready : req0_ready, 1);
    chk({tag, "_ready_other"}, sel ? req0_ready : req1_ready, 0);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic take_rsp(input string tag, input bit id, input logic [15:0] sum, input bit cout);
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_sum"}, rsp_sum, sum);
    chk({tag, "_cout"}, rsp_cout, cout);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, rsp_valid, 0);
  endtask

  initial begin
    int acc_prev;
    int seen;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready = 1'b0;
    cyc(); cyc();

    // Reset state: readies stay low even with a request pending.
    req0_valid = 1'b1;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_sum", rsp_sum, 16'h0000);
    chk("rst_rsp_cout", rsp_cout, 0);
    req0_valid = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();

    // Small add with carry-in.
    issue("t1", 1'b0, 16'h0004, 16'h0007, 1'b1);
    wait_rsp("t1", 4);
    take_rsp("t1", 1'b0, 16'h000C, 1'b0);

    // Carry ripples through every nibble.
    issue("t2", 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    wait_rsp("t2", 4);
    take_rsp("t2", 1'b1, 16'h0000, 1'b1);

    // Top nibble carry from a3 & b3.
    issue("t3", 1'b0, 16'h8000, 16'h8000, 1'b0);
    wait_rsp("t3", 4);
    take_rsp("t3", 1'b0, 16'h0000, 1'b1);

    // Round robin from reset with both requesters held and the consumer always ready.
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h0005; req0_b = 16'h0002; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0008; req1_b = 16'h0005; req1_cin = 1'b1;
    rsp_ready = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    acc_prev = 0;
    for (int i = 0; i < 4; i++) begin
      chk("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_ready1", req1_ready, (i % 2 == 1) ? 1 : 0);
      cyc();
      if (i > 0) chk("rr_accept_spacing", cycle - acc_prev, 6);
      acc_prev = cycle;
      wait_rsp("rr", 4);
      chk("rr_id", rsp_id, i % 2);
      chk("rr_sum", rsp_sum, (i % 2 == 0) ? 16'h0007 : 16'h000E);
      cyc();
      chk("rr_valid_drop", rsp_valid, 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b0;
    // Let the in-flight op from the still-asserted valids (if any) finish.
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) begin
        rsp_ready = 1'b1;
        seen = 1;
      end
      cyc();
      rsp_ready = 1'b0;
    end

    // Backpressure: result holds for 3 cycles, readies stay low, one transfer.
    issue("t5", 1'b1, 16'h1111, 16'h2222, 1'b0);
    wait_rsp("t5", 4);
    req0_valid = 1'b1; req0_a = 16'h0101; req0_b = 16'h0101; req0_cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_hold_valid", rsp_valid, 1);
      chk("t5_hold_id", rsp_id, 1);
      chk("t5_hold_sum", rsp_sum, 16'h3333);
      chk("t5_hold_cout", rsp_cout, 0);
      chk("t5_hold_ready0", req0_ready, 0);
      chk("t5_hold_ready1", req1_ready, 0);
    end
    req0_valid = 1'b0;
    take_rsp("t5", 1'b1, 16'h3333, 1'b0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) seen = 1;
      cyc();
    end
    chk("t5_single_transfer", seen, 0);

    // Reset during the second ADD cycle aborts the op.
    issue("t6", 1'b0, 16'hAAAA, 16'h1111, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("t6_rst_valid", rsp_valid, 0);
    chk("t6_rst_id", rsp_id, 0);
    chk("t6_rst_sum", rsp_sum, 16'h0000);
    chk("t6_rst_cout", rsp_cout, 0);
    chk("t6_rst_ready0", req0_ready, 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen = 1;
      cyc();
    end
    chk("t6_no_rsp", seen, 0);
    issue("t6b", 1'b0, 16'h1234, 16'h4321, 1'b0);
    wait_rsp("t6b", 4);
    take_rsp("t6b", 1'b0, 16'h5555, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
